midi_rx_parser: RTL and testbench
=================================

# midi_rx_parser

Serial MIDI receiver and message parser for the wubsuit base board. Samples the `MIDI_RX` pin at 31250 baud, 8N1, and assembles channel-voice messages, honouring running status. It also passes through single-byte real-time messages. Completed messages go to the MSS fabric interface over a valid/ready handshake. It is the receive-side counterpart of the existing `MIDI_TX` path.

## Interface

**Parameters**
- `CLK_DIV`, default 320: `SYSCLK` cycles per bit (10 MHz / 31250). Must be even and ≥ 16.

**Ports**
- `SYSCLK`  in  1  system clock.
- `NSYSRESET`  in  1  asynchronous, active-low reset.
- `MIDI_RX`  in  1  asynchronous serial line, idle high.
- `msg_ready`  in  1  consumer accepts the held message.
- `msg_valid`  out  1  a message is held on the `msg_*` outputs.
- `msg_status`  out  8  status byte.
- `msg_data1`  out  7  first data byte; 0 if absent.
- `msg_data2`  out  7  second data byte; 0 if absent.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: a completed message was dropped.

## Operation

**Reset and synchronisation**
- Reset values: all outputs 0. Synchroniser flops 1. Receiver in IDLE. Running status cleared. Data count 0.
- `MIDI_RX` passes through a 2-flop synchroniser. Falling-edge detection uses the synchronised value and its previous copy.

**Receiver FSM**
- IDLE: on a falling edge, go to START and load the bit counter.
- START: at `CLK_DIV/2` cycles, sample the line.
  - High: false start, return to IDLE.
  - Low: go to DATA.
- DATA: sample every `CLK_DIV` cycles, 8 bits, LSB first, into a shift register.
- STOP: sample after `CLK_DIV` cycles.
  - High: one-cycle internal `byte_valid`, return to IDLE.
  - Low: pulse `framing_err`, discard the byte, go to BREAK.
- BREAK: wait for the synchronised line to be high, then go to IDLE.

**Parser, per `byte_valid`**
- 0xF8–0xFF (real-time): emit immediately as a message with data1 = data2 = 0. Running status and partial message are untouched.
- 0xF0–0xF7 (system common / SysEx): clear running status. Following data bytes are discarded until the next status byte.
- 0x80–0xEF: store as running status; reset the data count.
  - Expected data bytes: 1 for 0xC0–0xDF, 2 otherwise.
- Data byte (bit7 = 0):
  - No running status: discard.
  - Otherwise store into data1, then data2.
  - When the expected count is reached: emit a message, reset the count, keep running status.
- Note-on with velocity 0 is emitted unchanged (no conversion to note-off).

**Output register**
- Emitting with `msg_valid` = 0: load the outputs and set `msg_valid`.
- `msg_valid` clears the cycle after `msg_valid && msg_ready`.
- Emit while `msg_valid && !msg_ready`: drop the new message, pulse `overrun`, hold the old message unchanged.
- Emit in the same cycle as a `msg_valid && msg_ready` handshake: load the new message; `msg_valid` stays 1.
- Outputs are stable while `msg_valid` = 1 and not accepted.

**Mid-operation reset**
- Asserting `NSYSRESET` at any point returns everything to the reset values.
- A byte in progress is lost. Running status is cleared.

## Timing

- Let E be the cycle the synchronised falling edge is detected, and C = `CLK_DIV`.
  - Start sample at E + C/2.
  - Data bit n (0–7) sampled at E + C/2 + (n+1)·C.
  - Stop sample at E + C/2 + 9·C.
- `msg_valid` (or `framing_err`) registers high one cycle after the stop sample of the completing byte.
- Pin-to-E latency: 3 cycles.
- `overrun` and `framing_err` are exactly one cycle wide.
- Minimum back-to-back byte spacing tolerated: 10·C (stop bit directly followed by the next start bit).
- Per-byte receive time: 10·C. A handshake-free consumer therefore sees at most one message per 10·C cycles.

## Test plan

All scenarios use `CLK_DIV` = 320 and a 10 MHz clock (bit = 32 µs).

- **Basic note-on.** Send 90 3C 64 with `msg_ready` = 1 → one `msg_valid` pulse with 0x90 / 0x3C / 0x64, asserted 1 + 160 + 2880 + 3 cycles after the last start edge.
- **Running status.** Send 90 3C 64 3E 00 → two messages: 90/3C/64, then 90/3E/00. No `framing_err`, no `overrun`.
- **One-byte message and interleaved real-time.** Send C5 07 → C5/07/00. Then send 90 F8 3C 64 → F8/00/00 first, then 90/3C/64.
- **Framing error.** Send 0x90 with the stop bit forced low for one bit, then idle high → `framing_err` pulses once, no message. Next, 80 3C 00 → 80/3C/00.
- **Backpressure.** Hold `msg_ready` = 0 and send 90 3C 64 90 3E 64 → first message held stable, one `overrun` pulse, second message lost. Raise `msg_ready` → `msg_valid` drops the next cycle.
- **Noise, orphan data, and reset.**
  - Low glitch of 100 cycles on the line → no byte.
  - After reset, send 3C 64 → no message.
  - Assert `NSYSRESET` during bit 4 of 0x90, then send 3C 64 → no message; all outputs read 0 during reset.

Source files
------------

// File: rtl/midi_rx_parser.sv
// MIDI serial receiver (8N1, CLK_DIV clocks per bit) with a running-status
// channel-voice parser and a single-entry valid/ready output register.
`timescale 1ns/1ps
module midi_rx_parser #(
  parameter int CLK_DIV = 320
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       MIDI_RX,
  input  logic       msg_ready,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_e;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  logic            fall;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_vld_q;
  logic            fe_pend_q;
  logic            framing_err_q;

  logic [7:0]      rs_q;
  logic            rs_vld_q;
  logic            dcnt_q;
  logic [6:0]      d1_q;
  logic            need_one;

  logic            emit;
  logic [7:0]      e_status;
  logic [6:0]      e_d1, e_d2;

  logic            msg_valid_q;
  logic [7:0]      msg_status_q;
  logic [6:0]      msg_data1_q, msg_data2_q;
  logic            overrun_q;

  assign fall = rx_prev_q & ~rx_s2_q;

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= MIDI_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Bit-timing FSM: the counter reaches zero on each sample point.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      byte_vld_q    <= 1'b0;
      fe_pend_q     <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      byte_vld_q    <= 1'b0;
      fe_pend_q     <= 1'b0;
      framing_err_q <= fe_pend_q;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            state_q <= S_START;
            cnt_q   <= HALF_M1;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              cnt_q   <= FULL_M1;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx_s2_q, shift_q[7:1]};
            cnt_q   <= FULL_M1;
            if (bit_q == 3'd7) state_q <= S_STOP;
            else               bit_q   <= bit_q + 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s2_q) begin
              byte_vld_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              fe_pend_q  <= 1'b1;
              state_q    <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s2_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Program change and channel pressure (0xC0-0xDF) carry one data byte.
  assign need_one = (rs_q[7:5] == 3'b110);

  always_comb begin
    emit     = 1'b0;
    e_status = shift_q;
    e_d1     = '0;
    e_d2     = '0;
    if (byte_vld_q) begin
      if (shift_q[7:3] == 5'b11111) begin
        emit = 1'b1;
      end else if (!shift_q[7] && rs_vld_q) begin
        if (dcnt_q) begin
          emit     = 1'b1;
          e_status = rs_q;
          e_d1     = d1_q;
          e_d2     = shift_q[6:0];
        end else if (need_one) begin
          emit     = 1'b1;
          e_status = rs_q;
          e_d1     = shift_q[6:0];
        end
      end
    end
  end

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      rs_q     <= '0;
      rs_vld_q <= 1'b0;
      dcnt_q   <= 1'b0;
      d1_q     <= '0;
    end else if (byte_vld_q) begin
      if (shift_q[7:3] == 5'b11111) begin
        rs_vld_q <= rs_vld_q;
      end else if (shift_q[7:4] == 4'hF) begin
        rs_vld_q <= 1'b0;
      end else if (shift_q[7]) begin
        rs_q     <= shift_q;
        rs_vld_q <= 1'b1;
        dcnt_q   <= 1'b0;
      end else if (rs_vld_q) begin
        if (dcnt_q) begin
          dcnt_q <= 1'b0;
        end else if (!need_one) begin
          d1_q   <= shift_q[6:0];
          dcnt_q <= 1'b1;
        end
      end
    end
  end

  // A message arriving while the previous one is unaccepted is dropped.
  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      msg_valid_q  <= 1'b0;
      msg_status_q <= '0;
      msg_data1_q  <= '0;
      msg_data2_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (emit && (!msg_valid_q || msg_ready)) begin
        msg_valid_q  <= 1'b1;
        msg_status_q <= e_status;
        msg_data1_q  <= e_d1;
        msg_data2_q  <= e_d2;
      end else if (emit) begin
        overrun_q <= 1'b1;
      end else if (msg_valid_q && msg_ready) begin
        msg_valid_q <= 1'b0;
      end
    end
  end

  assign msg_valid   = msg_valid_q;
  assign msg_status  = msg_status_q;
  assign msg_data1   = msg_data1_q;
  assign msg_data2   = msg_data2_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_midi_rx_parser.sv
// Scoreboard bench for midi_rx_parser: serial stimulus, expected messages queued
// as bytes are sent and checked at each output handshake.
`timescale 1ns/1ps
module tb_midi_rx_parser;

  // Reduced bit period keeps the run short; all timing is derived from C.
  localparam int C = 64;

  logic       SYSCLK = 1'b0;
  logic       NSYSRESET = 1'b0;
  logic       MIDI_RX = 1'b1;
  logic       msg_ready = 1'b1;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic       framing_err, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ovr_cnt = 0;
  int vld_cnt = 0;
  logic [21:0] exp_q[$];

  midi_rx_parser #(.CLK_DIV(C)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET), .MIDI_RX(MIDI_RX),
    .msg_ready(msg_ready), .msg_valid(msg_valid), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2),
    .framing_err(framing_err), .overrun(overrun)
  );

  initial forever #50 SYSCLK = ~SYSCLK;

  always @(negedge SYSCLK) begin
    if (framing_err) fe_cnt++;
    if (overrun) ovr_cnt++;
    if (msg_valid && msg_ready) begin
      vld_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_msg: got %h/%h/%h, expected no message",
                 msg_status, msg_data1, msg_data2);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        if ({msg_status, msg_data1, msg_data2} !== e) begin
          n_bad++;
          $display("FAIL msg_content: got %h/%h/%h, expected %h/%h/%h",
                   msg_status, msg_data1, msg_data2, e[21:14], e[13:7], e[6:0]);
        end
      end
    end
  end

  task automatic send_bit(input logic v);
    MIDI_RX = v;
    repeat (C) @(posedge SYSCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic push(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2);
    exp_q.push_back({s, d1, d2});
  endtask

  task automatic idle(input int n);
    MIDI_RX = 1'b1;
    repeat (n) @(posedge SYSCLK);
    #1;
  endtask

  task automatic test_reset;
    int v0;
    NSYSRESET = 1'b0;
    repeat (3) @(posedge SYSCLK);
    #1;
    n_cmp++;
    if ({msg_valid, msg_status, msg_data1, msg_data2, framing_err, overrun} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {msg_valid, msg_status, msg_data1, msg_data2, framing_err, overrun});
    end
    NSYSRESET = 1'b1;
    idle(4);
    v0 = vld_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    idle(2 * C);
    n_cmp++;
    if (vld_cnt - v0 !== 0) begin
      n_bad++;
      $display("FAIL orphan_after_reset: got %0d messages, expected 0", vld_cnt - v0);
    end
  endtask

  task automatic test_note_on_running;
    int lat, fe0, ov0;
    fe0 = fe_cnt;
    ov0 = ovr_cnt;
    push(8'h90, 7'h3C, 7'h64);
    push(8'h90, 7'h3E, 7'h00);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    lat = -1;
    fork
      send_byte(8'h64, 1'b1);
      begin
        for (int i = 1; i <= 10 * C; i++) begin
          @(posedge SYSCLK);
          #1;
          if (msg_valid && lat < 0) lat = i;
        end
      end
    join
    n_cmp++;
    if (lat !== 4 + C / 2 + 9 * C) begin
      n_bad++;
      $display("FAIL note_on_latency: got %0d cycles, expected %0d", lat, 4 + C / 2 + 9 * C);
    end
    send_byte(8'h3E, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2 * C);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL running_status_drain: got %0d pending, expected 0", exp_q.size());
    end
    n_cmp++;
    if ((fe_cnt - fe0) !== 0 || (ovr_cnt - ov0) !== 0) begin
      n_bad++;
      $display("FAIL running_status_flags: got fe=%0d ovr=%0d, expected 0/0",
               fe_cnt - fe0, ovr_cnt - ov0);
    end
  endtask

  task automatic test_realtime;
    push(8'hC5, 7'h07, 7'h00);
    push(8'hF8, 7'h00, 7'h00);
    push(8'h90, 7'h3C, 7'h64);
    send_byte(8'hC5, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h90, 1'b1);
    send_byte(8'hF8, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    idle(2 * C);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL realtime_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_framing;
    int fe0, v0;
    fe0 = fe_cnt;
    v0 = vld_cnt;
    send_byte(8'h90, 1'b0);
    idle(2 * C);
    n_cmp++;
    if ((fe_cnt - fe0) !== 1) begin
      n_bad++;
      $display("FAIL framing_pulse: got %0d cycles, expected 1", fe_cnt - fe0);
    end
    n_cmp++;
    if ((vld_cnt - v0) !== 0) begin
      n_bad++;
      $display("FAIL framing_no_msg: got %0d messages, expected 0", vld_cnt - v0);
    end
    push(8'h80, 7'h3C, 7'h00);
    send_byte(8'h80, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    idle(2 * C);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL framing_recover: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    int ov0;
    ov0 = ovr_cnt;
    msg_ready = 1'b0;
    push(8'h90, 7'h3C, 7'h64);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    n_cmp++;
    if ({msg_valid, msg_status, msg_data1, msg_data2} !== {1'b1, 8'h90, 7'h3C, 7'h64}) begin
      n_bad++;
      $display("FAIL bp_first_held: got %b %h/%h/%h, expected 1 90/3c/64",
               msg_valid, msg_status, msg_data1, msg_data2);
    end
    send_byte(8'h90, 1'b1);
    send_byte(8'h3E, 1'b1);
    send_byte(8'h64, 1'b1);
    n_cmp++;
    if ({msg_valid, msg_status, msg_data1, msg_data2} !== {1'b1, 8'h90, 7'h3C, 7'h64}) begin
      n_bad++;
      $display("FAIL bp_stable: got %b %h/%h/%h, expected 1 90/3c/64",
               msg_valid, msg_status, msg_data1, msg_data2);
    end
    n_cmp++;
    if ((ovr_cnt - ov0) !== 1) begin
      n_bad++;
      $display("FAIL bp_overrun: got %0d cycles, expected 1", ovr_cnt - ov0);
    end
    msg_ready = 1'b1;
    @(posedge SYSCLK);
    #1;
    n_cmp++;
    if (msg_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_valid_drop: got %b, expected 0", msg_valid);
    end
    idle(C);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_noise;
    int fe0, v0;
    fe0 = fe_cnt;
    v0 = vld_cnt;
    MIDI_RX = 1'b0;
    repeat (C * 5 / 16) @(posedge SYSCLK);
    #1;
    idle(12 * C);
    n_cmp++;
    if ((vld_cnt - v0) !== 0 || (fe_cnt - fe0) !== 0) begin
      n_bad++;
      $display("FAIL glitch: got msgs=%0d fe=%0d, expected 0/0", vld_cnt - v0, fe_cnt - fe0);
    end
  endtask

  task automatic test_mid_reset;
    int v0;
    logic [7:0] b;
    b = 8'h90;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    MIDI_RX = b[4];
    repeat (C / 2) @(posedge SYSCLK);
    #1;
    NSYSRESET = 1'b0;
    MIDI_RX = 1'b1;
    repeat (3) @(posedge SYSCLK);
    #1;
    n_cmp++;
    if ({msg_valid, msg_status, msg_data1, msg_data2, framing_err, overrun} !== 25'd0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %b, expected all zero",
               {msg_valid, msg_status, msg_data1, msg_data2, framing_err, overrun});
    end
    NSYSRESET = 1'b1;
    idle(2 * C);
    v0 = vld_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    idle(2 * C);
    n_cmp++;
    if ((vld_cnt - v0) !== 0) begin
      n_bad++;
      $display("FAIL mid_reset_orphan: got %0d messages, expected 0", vld_cnt - v0);
    end
  endtask

  initial begin
    test_reset();
    test_note_on_running();
    test_realtime();
    test_framing();
    test_backpressure();
    test_noise();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
